read_mirror_checker: RTL and testbench
======================================

Name: read_mirror_checker

Overview:
- Sits directly downstream of the instruction decoder in the SPI flash RAID path.
- Consumes the decoder's flash_select, state, instruction and address outputs.
- Steers the host MISO line from the selected flash, main or secondary, and freezes that choice for the whole read data phase.
- During qualifying reads it samples both flashes' MISO in parallel, compares them byte by byte, and keeps mirror-integrity statistics for RAID verification.

Parameters:
CNT_W, 16, width of read_txn_count and mismatch_count (saturating)

Ports:
clk  input  1  system clock (50 MHz); the only clock in this block
rst_n  input  1  reset, asynchronous, active-low
h_cs_n  input  1  host SPI chip select, raw/asynchronous
h_clk  input  1  host SPI clock, raw/asynchronous
m_miso  input  1  MISO from main flash, raw
s_miso  input  1  MISO from secondary flash, raw
flash_select  input  1  decoder route request (0 main, 1 secondary)
decoder_state  input  3  decoder state (0 IDLE, 1 CMD, 2 ADDR, 3 DUMMY, 4 DATA)
debug_instruction  input  8  decoder's latched opcode
debug_address  input  24  decoder's latched 24-bit start address
compare_enable  input  1  arm byte comparison; sampled at data-phase entry
clear_stats  input  1  synchronous clear of all statistics
h_miso  output  1  combinational: route_sel ? s_miso : m_miso (raw inputs)
route_sel  output  1  registered MISO route
read_txn_count  output  CNT_W  compared read transactions, saturating
mismatch_count  output  CNT_W  mismatching bytes, saturating
first_mismatch_addr  output  24  flash address of first mismatching byte since clear
mismatch_valid  output  1  first_mismatch_addr holds a captured value
mismatch_pulse  output  1  one-cycle strobe per mismatching byte

Behaviour:
- Synchronizers: 2-flop chains on h_clk, h_cs_n, m_miso and s_miso.
  - Reset values: h_clk 0, h_cs_n 1, miso 0.
  - sclk_rise = clk_r1 & ~clk_r2; cs_rise = cs_r1 & ~cs_r2.
  - Data bits are sampled from the r1 stage of each MISO chain.
- Requirement on h_clk: high and low phases each at least 4 clk cycles.
- Reset (rst_n low, async): route_sel 0, both counters 0, first_mismatch_addr 0, mismatch_valid 0, mismatch_pulse 0, FSM in C_IDLE, shift registers and bit counter 0.
- Routing:
  - route_sel <= flash_select on every cycle where decoder_state != 4.
  - route_sel is held while decoder_state == 4, even if flash_select toggles.
  - h_miso has zero-cycle latency from the raw MISO inputs.
- Compare FSM, states C_IDLE and C_DATA:
  - dstate_q is decoder_state registered one cycle.
  - Entry condition: decoder_state == 4, dstate_q != 4, compare_enable = 1, and debug_instruction is 0x03 or 0x0B.
  - On entry: go C_IDLE -> C_DATA; byte_addr <= debug_address; bit_cnt <= 0; both shift registers <= 0; read_txn_count++ (saturating).
  - When the entry condition fails (any other opcode, or compare_enable = 0): stay in C_IDLE, no counter change.
  - In C_DATA, on each sclk_rise with cs_r1 low: shift m/s MISO bits in MSB-first and increment bit_cnt.
  - On the 8th bit (bit_cnt == 7): form both full bytes including the current bit, then reset bit_cnt to 0.
  - If the two bytes differ: mismatch_count++ (saturating), mismatch_pulse = 1 for the next single cycle.
  - On the first mismatch while mismatch_valid = 0: first_mismatch_addr <= byte_addr, mismatch_valid <= 1.
  - byte_addr increments after every completed byte, wrapping 0xFFFFFF -> 0x000000.
  - C_DATA -> C_IDLE on cs_rise or decoder_state != 4. Any partial byte is discarded with no compare.
- Saturation: both counters stick at all-ones.
- clear_stats: zeroes both counters, first_mismatch_addr and mismatch_valid. When asserted in the same cycle as an increment or capture, clear wins. It does not alter FSM state or route_sel.
- Reset asserted mid-transaction aborts immediately. After release, the FSM stays in C_IDLE until the next fresh entry into decoder_state 4.

Test Plan:
1. Reset with rst_n low mid-stream -> all outputs 0 within the same cycle; h_miso == m_miso.
2. compare_enable = 1; read 0x03 to addr 0x001000; both flashes return A5,3C,FF,00 -> read_txn_count 1, mismatch_count 0, mismatch_valid 0, no mismatch_pulse.
3. Same read but s_miso returns 0x3D as the 2nd byte -> mismatch_count 1, first_mismatch_addr 0x001001, mismatch_valid 1, exactly one 1-cycle pulse. A later mismatch at 0x001003 gives count 2 and the captured address stays 0x001001.
4. flash_select = 1 at data-phase entry, toggled to 0 mid-data -> route_sel stays 1 and h_miso tracks s_miso until cs_rise / decoder IDLE; then route_sel follows flash_select again.
5. Page program 0x02 with differing MISO, and a 0x0B read with CS raised after 5 data bits -> no counter change from the 0x02; read_txn_count +1 and mismatch_count +0 for the truncated 0x0B.
6. Fast read at 0xFFFFFF with 2nd byte mismatching -> first_mismatch_addr 0x000000. Then clear_stats coincident with a mismatch -> both counts 0, mismatch_valid 0. Force counts to 0xFFFF -> further mismatches hold at 0xFFFF.

Source files
------------

// File: rtl/read_mirror_checker_if.sv
// Bundles the SPI pins, decoder status and mirror statistics seen by read_mirror_checker.
// The checker connects through the slave modport; the driving environment uses the master one.
interface read_mirror_checker_if #(
    parameter int CNT_W = 16
);
    logic             h_cs_n;
    logic             h_clk;
    logic             m_miso;
    logic             s_miso;
    logic             flash_select;
    logic [2:0]       decoder_state;
    logic [7:0]       debug_instruction;
    logic [23:0]      debug_address;
    logic             compare_enable;
    logic             clear_stats;
    logic             h_miso;
    logic             route_sel;
    logic [CNT_W-1:0] read_txn_count;
    logic [CNT_W-1:0] mismatch_count;
    logic [23:0]      first_mismatch_addr;
    logic             mismatch_valid;
    logic             mismatch_pulse;

    modport master (
        output h_cs_n, h_clk, m_miso, s_miso, flash_select, decoder_state,
               debug_instruction, debug_address, compare_enable, clear_stats,
        input  h_miso, route_sel, read_txn_count, mismatch_count,
               first_mismatch_addr, mismatch_valid, mismatch_pulse
    );

    modport slave (
        input  h_cs_n, h_clk, m_miso, s_miso, flash_select, decoder_state,
               debug_instruction, debug_address, compare_enable, clear_stats,
        output h_miso, route_sel, read_txn_count, mismatch_count,
               first_mismatch_addr, mismatch_valid, mismatch_pulse
    );
endinterface

// File: rtl/read_mirror_checker.sv
// Routes host MISO from the main or secondary flash and, during qualifying reads,
// compares both flashes byte by byte to keep mirror-integrity statistics.
module read_mirror_checker #(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    read_mirror_checker_if.slave  bus
);
    // state  | meaning
    // C_IDLE | waiting for a fresh entry into a comparable read data phase
    // C_DATA | shifting both MISO streams and comparing completed bytes
    typedef enum logic {C_IDLE, C_DATA} cstate_t;

    localparam logic [2:0] D_DATA = 3'd4;

    // Bit 0 of each chain is the r1 stage, bit 1 the r2 stage.
    logic [1:0]       clk_sync_q, cs_sync_q, m_sync_q, s_sync_q;
    logic [2:0]       dstate_q;
    cstate_t          cstate_q;
    logic             route_sel_q;
    logic [23:0]      byte_addr_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       m_sh_q, s_sh_q;
    logic [CNT_W-1:0] read_txn_q, read_txn_d;
    logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
    logic [23:0]      first_addr_q;
    logic             mismatch_valid_q;
    logic             mismatch_pulse_q;

    logic             sclk_rise, cs_rise;
    logic             entry, leave, bit_take, byte_done, byte_mis;
    logic [7:0]       m_byte, s_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= 2'b00;
            cs_sync_q  <= 2'b11;
            m_sync_q   <= 2'b00;
            s_sync_q   <= 2'b00;
        end else begin
            clk_sync_q <= {clk_sync_q[0], bus.h_clk};
            cs_sync_q  <= {cs_sync_q[0], bus.h_cs_n};
            m_sync_q   <= {m_sync_q[0], bus.m_miso};
            s_sync_q   <= {s_sync_q[0], bus.s_miso};
        end
    end

    assign sclk_rise = clk_sync_q[0] & ~clk_sync_q[1];
    assign cs_rise   = cs_sync_q[0] & ~cs_sync_q[1];

    always_comb begin
        entry = (cstate_q == C_IDLE) && (bus.decoder_state == D_DATA) &&
                (dstate_q != D_DATA) && bus.compare_enable &&
                ((bus.debug_instruction == 8'h03) || (bus.debug_instruction == 8'h0B));
        leave     = (cstate_q == C_DATA) && (cs_rise || (bus.decoder_state != D_DATA));
        bit_take  = (cstate_q == C_DATA) && !leave && sclk_rise && !cs_sync_q[0];
        m_byte    = {m_sh_q[6:0], m_sync_q[0]};
        s_byte    = {s_sh_q[6:0], s_sync_q[0]};
        byte_done = bit_take && (bit_cnt_q == 3'd7);
        byte_mis  = byte_done && (m_byte != s_byte);

        read_txn_d     = read_txn_q;
        mismatch_cnt_d = mismatch_cnt_q;
        if (entry && (read_txn_q != '1))
            read_txn_d = read_txn_q + 1'b1;
        if (byte_mis && (mismatch_cnt_q != '1))
            mismatch_cnt_d = mismatch_cnt_q + 1'b1;
    end

    // dstate_q resets to the data code so a decoder already sitting in DATA
    // when reset releases cannot look like a fresh data-phase entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dstate_q         <= D_DATA;
            cstate_q         <= C_IDLE;
            route_sel_q      <= 1'b0;
            byte_addr_q      <= '0;
            bit_cnt_q        <= '0;
            m_sh_q           <= '0;
            s_sh_q           <= '0;
            read_txn_q       <= '0;
            mismatch_cnt_q   <= '0;
            first_addr_q     <= '0;
            mismatch_valid_q <= 1'b0;
            mismatch_pulse_q <= 1'b0;
        end else begin
            dstate_q         <= bus.decoder_state;
            mismatch_pulse_q <= byte_mis;
            if (bus.decoder_state != D_DATA)
                route_sel_q <= bus.flash_select;

            case (cstate_q)
                C_IDLE: begin
                    if (entry) begin
                        cstate_q    <= C_DATA;
                        byte_addr_q <= bus.debug_address;
                        bit_cnt_q   <= '0;
                        m_sh_q      <= '0;
                        s_sh_q      <= '0;
                    end
                end
                C_DATA: begin
                    if (leave) begin
                        cstate_q <= C_IDLE;
                    end else if (bit_take) begin
                        m_sh_q    <= m_byte;
                        s_sh_q    <= s_byte;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (byte_done)
                            byte_addr_q <= byte_addr_q + 24'd1;
                    end
                end
                default: cstate_q <= C_IDLE;
            endcase

            if (bus.clear_stats) begin
                read_txn_q       <= '0;
                mismatch_cnt_q   <= '0;
                first_addr_q     <= '0;
                mismatch_valid_q <= 1'b0;
            end else begin
                read_txn_q     <= read_txn_d;
                mismatch_cnt_q <= mismatch_cnt_d;
                if (byte_mis && !mismatch_valid_q) begin
                    first_addr_q     <= byte_addr_q;
                    mismatch_valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.h_miso              = route_sel_q ? bus.s_miso : bus.m_miso;
    assign bus.route_sel           = route_sel_q;
    assign bus.read_txn_count      = read_txn_q;
    assign bus.mismatch_count      = mismatch_cnt_q;
    assign bus.first_mismatch_addr = first_addr_q;
    assign bus.mismatch_valid      = mismatch_valid_q;
    assign bus.mismatch_pulse      = mismatch_pulse_q;
endmodule

// File: tb/tb_read_mirror_checker.sv
// Directed bench for read_mirror_checker: routing, mirror compare, opcode filter,
// address wrap, clear priority and counter saturation.
module tb_read_mirror_checker;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   pulse_cnt = 0;

    always #10 clk = ~clk;

    read_mirror_checker_if #(.CNT_W(16)) bus ();
    read_mirror_checker #(.CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always @(negedge clk) if (bus.mismatch_pulse === 1'b1) pulse_cnt++;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic begin_read(input logic [7:0] op, input logic [23:0] addr, input logic fsel);
        bus.debug_instruction = op;
        bus.debug_address     = addr;
        bus.flash_select      = fsel;
        bus.h_clk             = 1'b0;
        bus.h_cs_n            = 1'b0;
        bus.decoder_state     = 3'd1;
        wait_clk(4);
        bus.decoder_state = 3'd2;
        wait_clk(4);
        bus.decoder_state = 3'd4;
        wait_clk(4);
    endtask

    // Sends the top n bits MSB-first, 4 clk per h_clk phase.
    task automatic send_bits(input logic [7:0] m, input logic [7:0] s, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            bus.h_clk  = 1'b0;
            bus.m_miso = m[i];
            bus.s_miso = s[i];
            wait_clk(4);
            bus.h_clk = 1'b1;
            wait_clk(4);
        end
    endtask

    task automatic end_read;
        bus.h_clk = 1'b0;
        wait_clk(4);
        bus.h_cs_n = 1'b1;
        wait_clk(4);
        bus.decoder_state = 3'd0;
        wait_clk(4);
    endtask

    task automatic test_reset;
        int p0;
        wait_clk(3);
        n_checks++; if (bus.route_sel !== 1'b0) begin n_fail++; $display("FAIL por_route got %b want 0", bus.route_sel); end
        n_checks++; if (bus.read_txn_count !== 16'd0) begin n_fail++; $display("FAIL por_txn got %0d want 0", bus.read_txn_count); end
        n_checks++; if (bus.mismatch_valid !== 1'b0 || bus.mismatch_pulse !== 1'b0) begin n_fail++; $display("FAIL por_flags got %b%b want 00", bus.mismatch_valid, bus.mismatch_pulse); end
        rst_n = 1'b1;
        wait_clk(2);
        begin_read(8'h03, 24'h000100, 1'b1);
        send_bits(8'hA5, 8'hA4, 8);
        n_checks++; if (bus.mismatch_count !== 16'd1) begin n_fail++; $display("FAIL pre_reset_mm got %0d want 1", bus.mismatch_count); end
        send_bits(8'hFF, 8'h00, 3);
        bus.m_miso = 1'b1;
        bus.s_miso = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.route_sel !== 1'b0) begin n_fail++; $display("FAIL rst_route got %b want 0", bus.route_sel); end
        n_checks++; if (bus.read_txn_count !== 16'd0 || bus.mismatch_count !== 16'd0) begin n_fail++; $display("FAIL rst_counts got %0d/%0d want 0/0", bus.read_txn_count, bus.mismatch_count); end
        n_checks++; if (bus.first_mismatch_addr !== 24'd0 || bus.mismatch_valid !== 1'b0 || bus.mismatch_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_capture got %h/%b/%b want 000000/0/0", bus.first_mismatch_addr, bus.mismatch_valid, bus.mismatch_pulse); end
        n_checks++; if (bus.h_miso !== 1'b1) begin n_fail++; $display("FAIL rst_h_miso got %b want 1 (m_miso)", bus.h_miso); end
        wait_clk(2);
        rst_n = 1'b1;
        p0 = pulse_cnt;
        send_bits(8'h12, 8'h34, 8);
        send_bits(8'h56, 8'h78, 8);
        n_checks++; if (bus.read_txn_count !== 16'd0 || bus.mismatch_count !== 16'd0 || pulse_cnt != p0) begin n_fail++; $display("FAIL post_reset_idle got txn %0d mm %0d pulses %0d want 0 0 0", bus.read_txn_count, bus.mismatch_count, pulse_cnt - p0); end
        end_read();
    endtask

    task automatic test_matching_read;
        int p0;
        p0 = pulse_cnt;
        begin_read(8'h03, 24'h001000, 1'b0);
        send_bits(8'hA5, 8'hA5, 8);
        send_bits(8'h3C, 8'h3C, 8);
        send_bits(8'hFF, 8'hFF, 8);
        send_bits(8'h00, 8'h00, 8);
        end_read();
        n_checks++; if (bus.read_txn_count !== 16'd1) begin n_fail++; $display("FAIL match_txn got %0d want 1", bus.read_txn_count); end
        n_checks++; if (bus.mismatch_count !== 16'd0 || bus.mismatch_valid !== 1'b0) begin n_fail++; $display("FAIL match_mm got %0d/%b want 0/0", bus.mismatch_count, bus.mismatch_valid); end
        n_checks++; if (pulse_cnt != p0) begin n_fail++; $display("FAIL match_pulse got %0d want 0", pulse_cnt - p0); end
    endtask

    task automatic test_mismatch;
        int p0;
        p0 = pulse_cnt;
        begin_read(8'h03, 24'h001000, 1'b0);
        send_bits(8'hA5, 8'hA5, 8);
        send_bits(8'h3C, 8'h3D, 8);
        n_checks++; if (bus.mismatch_count !== 16'd1) begin n_fail++; $display("FAIL mis1_count got %0d want 1", bus.mismatch_count); end
        n_checks++; if (bus.first_mismatch_addr !== 24'h001001 || bus.mismatch_valid !== 1'b1) begin n_fail++; $display("FAIL mis1_addr got %h/%b want 001001/1", bus.first_mismatch_addr, bus.mismatch_valid); end
        n_checks++; if (pulse_cnt != p0 + 1) begin n_fail++; $display("FAIL mis1_pulse got %0d want 1", pulse_cnt - p0); end
        send_bits(8'hFF, 8'hFF, 8);
        send_bits(8'h00, 8'h01, 8);
        n_checks++; if (bus.mismatch_count !== 16'd2 || bus.first_mismatch_addr !== 24'h001001) begin n_fail++; $display("FAIL mis2 got %0d/%h want 2/001001", bus.mismatch_count, bus.first_mismatch_addr); end
        n_checks++; if (pulse_cnt != p0 + 2) begin n_fail++; $display("FAIL mis2_pulse got %0d want 2", pulse_cnt - p0); end
        end_read();
        n_checks++; if (bus.read_txn_count !== 16'd2) begin n_fail++; $display("FAIL mis_txn got %0d want 2", bus.read_txn_count); end
    endtask

    task automatic test_routing;
        bus.compare_enable = 1'b0;
        begin_read(8'h03, 24'h000000, 1'b1);
        n_checks++; if (bus.route_sel !== 1'b1) begin n_fail++; $display("FAIL route_entry got %b want 1", bus.route_sel); end
        send_bits(8'h55, 8'hAA, 8);
        bus.flash_select = 1'b0;
        wait_clk(4);
        n_checks++; if (bus.route_sel !== 1'b1) begin n_fail++; $display("FAIL route_held got %b want 1", bus.route_sel); end
        bus.m_miso = 1'b0; bus.s_miso = 1'b1;
        #1;
        n_checks++; if (bus.h_miso !== 1'b1) begin n_fail++; $display("FAIL route_miso_hi got %b want 1", bus.h_miso); end
        bus.m_miso = 1'b1; bus.s_miso = 1'b0;
        #1;
        n_checks++; if (bus.h_miso !== 1'b0) begin n_fail++; $display("FAIL route_miso_lo got %b want 0", bus.h_miso); end
        end_read();
        n_checks++; if (bus.route_sel !== 1'b0 || bus.h_miso !== 1'b1) begin n_fail++; $display("FAIL route_release got %b/%b want 0/1", bus.route_sel, bus.h_miso); end
        n_checks++; if (bus.read_txn_count !== 16'd2) begin n_fail++; $display("FAIL route_disabled_txn got %0d want 2", bus.read_txn_count); end
        bus.compare_enable = 1'b1;
    endtask

    task automatic test_opcode_filter;
        int p0;
        p0 = pulse_cnt;
        begin_read(8'h02, 24'h002000, 1'b0);
        send_bits(8'h12, 8'h34, 8);
        send_bits(8'h56, 8'h78, 8);
        end_read();
        n_checks++; if (bus.read_txn_count !== 16'd2 || bus.mismatch_count !== 16'd2) begin n_fail++; $display("FAIL pp_counts got %0d/%0d want 2/2", bus.read_txn_count, bus.mismatch_count); end
        begin_read(8'h0B, 24'h003000, 1'b0);
        send_bits(8'hF0, 8'h0F, 5);
        end_read();
        n_checks++; if (bus.read_txn_count !== 16'd3 || bus.mismatch_count !== 16'd2) begin n_fail++; $display("FAIL trunc_counts got %0d/%0d want 3/2", bus.read_txn_count, bus.mismatch_count); end
        n_checks++; if (pulse_cnt != p0) begin n_fail++; $display("FAIL filter_pulse got %0d want 0", pulse_cnt - p0); end
    endtask

    task automatic test_wrap_clear_sat;
        bus.clear_stats = 1'b1;
        wait_clk(1);
        bus.clear_stats = 1'b0;
        n_checks++; if (bus.read_txn_count !== 16'd0 || bus.mismatch_count !== 16'd0 || bus.mismatch_valid !== 1'b0 || bus.first_mismatch_addr !== 24'd0) begin n_fail++; $display("FAIL clear got %0d/%0d/%b/%h want 0/0/0/000000", bus.read_txn_count, bus.mismatch_count, bus.mismatch_valid, bus.first_mismatch_addr); end
        begin_read(8'h0B, 24'hFFFFFF, 1'b0);
        send_bits(8'h11, 8'h11, 8);
        send_bits(8'h22, 8'h23, 8);
        n_checks++; if (bus.first_mismatch_addr !== 24'h000000 || bus.mismatch_valid !== 1'b1 || bus.mismatch_count !== 16'd1) begin n_fail++; $display("FAIL wrap got %h/%b/%0d want 000000/1/1", bus.first_mismatch_addr, bus.mismatch_valid, bus.mismatch_count); end
        send_bits(8'h80, 8'h81, 7);
        bus.h_clk = 1'b0; bus.m_miso = 1'b0; bus.s_miso = 1'b1;
        wait_clk(4);
        bus.clear_stats = 1'b1;
        bus.h_clk = 1'b1;
        wait_clk(4);
        bus.clear_stats = 1'b0;
        n_checks++; if (bus.read_txn_count !== 16'd0 || bus.mismatch_count !== 16'd0 || bus.mismatch_valid !== 1'b0) begin n_fail++; $display("FAIL clear_wins got %0d/%0d/%b want 0/0/0", bus.read_txn_count, bus.mismatch_count, bus.mismatch_valid); end
        end_read();
        force dut.read_txn_q = 16'hFFFF;
        force dut.mismatch_cnt_q = 16'hFFFF;
        wait_clk(1);
        release dut.read_txn_q;
        release dut.mismatch_cnt_q;
        begin_read(8'h03, 24'h000040, 1'b0);
        n_checks++; if (bus.read_txn_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_txn got %h want ffff", bus.read_txn_count); end
        send_bits(8'h01, 8'h02, 8);
        n_checks++; if (bus.mismatch_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_mm got %h want ffff", bus.mismatch_count); end
        n_checks++; if (bus.first_mismatch_addr !== 24'h000040 || bus.mismatch_valid !== 1'b1) begin n_fail++; $display("FAIL sat_capture got %h/%b want 000040/1", bus.first_mismatch_addr, bus.mismatch_valid); end
        end_read();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.h_cs_n            = 1'b1;
        bus.h_clk             = 1'b0;
        bus.m_miso            = 1'b0;
        bus.s_miso            = 1'b0;
        bus.flash_select      = 1'b0;
        bus.decoder_state     = 3'd0;
        bus.debug_instruction = 8'h00;
        bus.debug_address     = 24'h000000;
        bus.compare_enable    = 1'b1;
        bus.clear_stats       = 1'b0;
        test_reset();
        test_matching_read();
        test_mismatch();
        test_routing();
        test_opcode_filter();
        test_wrap_clear_sat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
